soc_system_nios2_qsys_0_mul_seq: RTL and testbench
==================================================

SOC_SYSTEM_NIOS2_QSYS_0_MUL_SEQ -- requirements
Module: soc_system_nios2_qsys_0_mul_seq

Interface
REQ-001 SHALL have clk, input, 1: the single clock; all state changes on its rising edge.
REQ-002 SHALL have reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have req_valid[1:0], input, 2: per-requester request valid.
REQ-004 SHALL have req_ready[1:0], output, 2: per-requester accept, at most one bit set.
REQ-005 SHALL have req0_a, req0_b, req1_a and req1_b, input, 32 each: unsigned operands.
REQ-006 SHALL have req0_op and req1_op, input, 1 each: 0 = MUL_LO (product bits 31:0), 1 = MUL_HI (product bits 63:32).
REQ-007 SHALL have rsp_valid, output, 1: result valid.
REQ-008 SHALL have rsp_ready, input, 1: consumer accept.
REQ-009 SHALL have rsp_id, output, 1: index of the served requester.
REQ-010 SHALL have rsp_result, output, 32: the selected product half.
REQ-011 SHALL have busy, output, 1: high in any state other than IDLE.

Function
REQ-012 SHALL time-share one 16x16 unsigned multiplier with a one-cycle registered output to form the full 64-bit product.
REQ-013 SHALL implement states IDLE, ISSUE, DRAIN and DONE.
- IDLE -> ISSUE on accept.
- ISSUE -> DRAIN after issue index 3.
- DRAIN -> DONE.
- DONE -> IDLE when rsp_valid and rsp_ready are both high.
REQ-014 SHALL drive req_ready non-zero only in IDLE, combinationally, for the granted requester among those with req_valid set.
REQ-015 SHALL arbitrate round-robin with a 1-bit priority pointer: a lone valid requester is granted, and when both are valid the pointer holder is granted.
REQ-016 SHALL set the priority pointer to the other requester after every accept.
REQ-017 SHALL capture a, b, op and id on accept, so that requester inputs are don't-care after the accept cycle.
REQ-018 SHALL, for an accept at cycle T, issue partial products in ISSUE at T+1..T+4 in index order 0..3.
- Index 0: a[15:0]*b[15:0], shift 0.
- Index 1: a[31:16]*b[15:0], shift 16.
- Index 2: a[15:0]*b[31:16], shift 16.
- Index 3: a[31:16]*b[31:16], shift 32.
REQ-019 SHALL add each registered partial product, shifted, into a 64-bit accumulator at T+2..T+5; the accumulator clears on accept, and the sum cannot overflow 64 bits.
REQ-020 SHALL assert rsp_valid at T+6, giving a fixed latency of 6 cycles from accept to rsp_valid.
REQ-021 SHALL hold rsp_valid, rsp_id and rsp_result stable while rsp_valid is high and rsp_ready is low.
REQ-022 SHALL make the earliest next accept the cycle after the response handshake, so at most one operation is in flight.
REQ-023 SHALL ignore rsp_ready outside DONE and req_valid outside IDLE.
REQ-024 SHALL drive rsp_result to 0 whenever rsp_valid is low.

Reset
REQ-025 SHALL, while reset is high, force state to IDLE, priority pointer to 0, issue index, accumulator and multiplier register to 0, and rsp_valid, busy and req_ready to 0.
REQ-026 SHALL abort any in-flight or pending operation when reset is asserted, with no response produced.
REQ-027 SHALL be ready to accept a request in the first cycle after reset deasserts.

Structure
REQ-028 SHALL place the state enum, op encodings (MUL_LO/MUL_HI), NUM_PP=4 and LATENCY=6 in a shared package, soc_system_nios2_qsys_0_mul_pkg.
REQ-029 SHALL instantiate one sub-module, soc_system_nios2_qsys_0_mul16_reg: a 16x16 unsigned multiplier with one output register and synchronous reset.

Verification
REQ-030 SHALL cover: req0 a=0x0001_0002, b=0x0003_0004, op=LO, accepted at cycle 10 -> rsp_valid at cycle 16, rsp_id=0, rsp_result=0x000A_0008; the same operands with op=HI -> 0x0000_0003.
REQ-031 SHALL cover: a=b=0xFFFF_FFFF -> LO=0x0000_0001 and HI=0xFFFF_FFFE.
REQ-032 SHALL cover: both req_valid high on the first cycle after reset -> req0 accepted first, req1 accepted the cycle after the first response handshake, rsp_id sequence 0,1.
REQ-033 SHALL cover: rsp_ready held low 5 cycles in DONE -> rsp fields stable, req_ready=0, busy=1, and the handshake on cycle 6 returns to IDLE.
REQ-034 SHALL cover: reset pulsed during issue index 2 -> next cycle rsp_valid=0, busy=0, and with both requesters valid req0 is granted.
REQ-035 SHALL cover: a=0, b=0xDEAD_BEEF, op=HI from req1 -> rsp_result=0, rsp_id=1.

Source files
------------

// File: rtl/soc_system_nios2_qsys_0_mul_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
package soc_system_nios2_qsys_0_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mul_state_e;

    // Operation select: which half of the 64-bit product is returned.
    localparam logic OP_MUL_LO = 1'b0;
    localparam logic OP_MUL_HI = 1'b1;

    // Number of 16x16 partial products and accept-to-rsp_valid latency.
    localparam int NUM_PP  = 4;
    localparam int LATENCY = 6;

    // Bit position of a partial product inside the 64-bit sum.
    function automatic logic [5:0] pp_shift(input logic [1:0] idx);
        case (idx)
            2'd0:    pp_shift = 6'd0;
            2'd3:    pp_shift = 6'd32;
            default: pp_shift = 6'd16;
        endcase
    endfunction

endpackage

// File: rtl/soc_system_nios2_qsys_0_mul16_reg.sv
// 16x16 unsigned multiplier with a single registered output.
module soc_system_nios2_qsys_0_mul16_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    // Product register; clears on synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            p <= 32'd0;
        end else begin
            p <= 32'(a) * 32'(b);
        end
    end

endmodule

// File: rtl/soc_system_nios2_qsys_0_mul_seq.sv
// Two-requester sequential 32x32 multiplier built on one 16x16 registered
// multiplier. Four partial products are issued, accumulated into a 64-bit
// sum, and the selected half is returned with a fixed 6-cycle latency.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is only offered in IDLE to the arbitration winner;
// rsp_valid stays high with stable rsp_id/rsp_result until rsp_ready is seen.
module soc_system_nios2_qsys_0_mul_seq
    import soc_system_nios2_qsys_0_mul_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        busy,
    output mul_state_e  dbg_state
);

    mul_state_e  state_q, state_d;
    logic        prio_q;
    logic [1:0]  idx_q;
    logic [31:0] a_q, b_q;
    logic        op_q, id_q;
    logic [63:0] acc_q;
    logic        acc_en_q;
    logic [1:0]  acc_idx_q;
    logic [1:0]  grant;
    logic        accept;
    logic        grant_id;
    logic        rsp_fire;
    logic [15:0] mul_a, mul_b;
    logic [31:0] mul_p;

    // Round-robin grant: a lone requester wins, otherwise the pointer holder.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE && !reset) ? grant : 2'b00;
    assign accept    = |req_ready;
    assign grant_id  = req_ready[1];
    assign rsp_valid = (state_q == ST_DONE) && !reset;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign busy      = (state_q != ST_IDLE) && !reset;
    assign dbg_state = state_q;

    assign rsp_id     = rsp_valid ? id_q : 1'b0;
    assign rsp_result = !rsp_valid ? 32'd0 :
                        (op_q == OP_MUL_HI) ? acc_q[63:32] : acc_q[31:0];

    // Next-state logic for the issue/drain/done sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: if (idx_q == 2'(NUM_PP - 1)) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  if (rsp_fire) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue index, priority pointer and the one-cycle-delayed accumulate tag
    // that lines up with the multiplier's output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q    <= 1'b0;
            idx_q     <= 2'd0;
            acc_en_q  <= 1'b0;
            acc_idx_q <= 2'd0;
        end else begin
            acc_en_q  <= (state_q == ST_ISSUE);
            acc_idx_q <= idx_q;
            if (accept) begin
                prio_q <= ~grant_id;
                idx_q  <= 2'd0;
            end else if (state_q == ST_ISSUE) begin
                idx_q  <= idx_q + 2'd1;
            end
        end
    end

    // Operand capture on accept; requester inputs are free afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            op_q <= 1'b0;
            id_q <= 1'b0;
        end else if (accept) begin
            a_q  <= grant_id ? req1_a  : req0_a;
            b_q  <= grant_id ? req1_b  : req0_b;
            op_q <= grant_id ? req1_op : req0_op;
            id_q <= grant_id;
        end
    end

    // Index bit 0 picks the upper half of a, bit 1 the upper half of b.
    always_comb begin
        mul_a = idx_q[0] ? a_q[31:16] : a_q[15:0];
        mul_b = idx_q[1] ? b_q[31:16] : b_q[15:0];
    end

    soc_system_nios2_qsys_0_mul16_reg u_mul16 (
        .clk   (clk),
        .reset (reset),
        .a     (mul_a),
        .b     (mul_b),
        .p     (mul_p)
    );

    // 64-bit accumulator: cleared on accept, adds each shifted partial product.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= 64'd0;
        end else if (accept) begin
            acc_q <= 64'd0;
        end else if (acc_en_q) begin
            acc_q <= acc_q + (64'(mul_p) << pp_shift(acc_idx_q));
        end
    end

endmodule

// File: tb/tb_soc_system_nios2_qsys_0_mul_seq.sv
// Self-checking bench for the sequential multiplier.
module tb_soc_system_nios2_qsys_0_mul_seq;
    import soc_system_nios2_qsys_0_mul_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_op = 1'b0, req1_op = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        busy;
    mul_state_e  dbg_state;

    soc_system_nios2_qsys_0_mul_seq dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int acc_cyc  = 0;
    logic [32:0] exp_q[$];   // {id, result}

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] exp;
        int          hold;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic op);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return (op == OP_MUL_HI) ? p[63:32] : p[31:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic id, input logic [31:0] a, input logic [31:0] b, input logic op);
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    // Called at a negedge after an accept; waits for the response, holds
    // rsp_ready low for 'hold' extra DONE cycles, then completes the handshake.
    task automatic wait_rsp(input int hold);
        int n;
        logic [32:0] e;
        logic [1:0] rv;
        n = 0;
        while (!rsp_valid && n < LATENCY + 10) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid_seen", rsp_valid, 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h0;
        if (!rsp_valid) return;
        chk("latency", 64'(cyc - acc_cyc), 64'(LATENCY));
        chk("rsp_id", rsp_id, e[32]);
        chk("rsp_result", rsp_result, e[31:0]);
        rv = req_valid;
        for (int i = 0; i < hold; i++) begin
            req_valid = 2'b11;
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_id", rsp_id, e[32]);
            chk("hold_result", rsp_result, e[31:0]);
            chk("hold_req_ready", req_ready, 2'b00);
            chk("hold_busy", busy, 1);
        end
        req_valid = rv;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_busy", busy, 0);
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_rsp_result", rsp_result, 0);
    endtask

    task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic [31:0] exp, input int hold);
        int n;
        @(posedge clk);
        #1;
        drive_req(id, a, b, op);
        req_valid[id] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[id] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept", req_ready, id ? 2'b10 : 2'b01);
        if (req_ready[id]) begin
            acc_cyc = cyc;
            exp_q.push_back({id, exp});
            @(posedge clk);
            #1;
            req_valid = 2'b00;
            drive_req(id, $urandom, $urandom, 1'($urandom_range(0, 1)));
            @(negedge clk);
            wait_rsp(hold);
        end else begin
            req_valid = 2'b00;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic        rid, rop;
        logic [31:0] ra, rb;

        vecs[0] = '{1'b0, 32'h0001_0002, 32'h0003_0004, OP_MUL_LO, 32'h000A_0008, 0};
        vecs[1] = '{1'b0, 32'h0001_0002, 32'h0003_0004, OP_MUL_HI, 32'h0000_0003, 0};
        vecs[2] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MUL_LO, 32'h0000_0001, 0};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MUL_HI, 32'hFFFF_FFFE, 5};
        vecs[4] = '{1'b1, 32'h0000_0000, 32'hDEAD_BEEF, OP_MUL_HI, 32'h0000_0000, 0};
        vecs[5] = '{1'b1, 32'h0001_0000, 32'h0001_0000, OP_MUL_HI, 32'h0000_0001, 1};

        // Reset with both requesters already valid.
        reset = 1'b1;
        drive_req(1'b0, 32'd7, 32'd9, OP_MUL_LO);
        drive_req(1'b1, 32'h1234_5678, 32'h10, OP_MUL_HI);
        req_valid = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        @(posedge clk);
        #1 reset = 1'b0;

        // Both valid in the first cycle after reset: req0 then req1.
        @(negedge clk);
        chk("first_grant", req_ready, 2'b01);
        acc_cyc = cyc;
        exp_q.push_back({1'b0, model(32'd7, 32'd9, OP_MUL_LO)});
        @(posedge clk);
        #1 req_valid = 2'b10;
        drive_req(1'b0, 32'hDEAD_0000, 32'h0000_BEEF, OP_MUL_HI);
        @(negedge clk);
        wait_rsp(0);
        chk("second_grant", req_ready, 2'b10);
        if (req_ready[1]) begin
            acc_cyc = cyc;
            exp_q.push_back({1'b1, model(32'h1234_5678, 32'h10, OP_MUL_HI)});
            @(posedge clk);
            #1 req_valid = 2'b00;
            @(negedge clk);
            wait_rsp(0);
        end
        req_valid = 2'b00;

        // Table of directed vectors.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].hold);
        end

        // Random vectors against the 64-bit reference model.
        for (int i = 0; i < 8; i++) begin
            rid = 1'($urandom_range(0, 1));
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            run_op(rid, ra, rb, rop, model(ra, rb, rop), $urandom_range(0, 2));
        end

        // Abort during issue index 2; pointer must return to req0.
        @(posedge clk);
        #1 drive_req(1'b0, 32'hCAFE_F00D, 32'h1357_9BDF, OP_MUL_LO);
        req_valid = 2'b01;
        @(negedge clk);
        chk("abort_accept", req_ready, 2'b01);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("abort_in_issue", dbg_state, ST_ISSUE);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        drive_req(1'b0, 32'h0000_0100, 32'h0000_0200, OP_MUL_LO);
        drive_req(1'b1, 32'h0000_0003, 32'h0000_0005, OP_MUL_LO);
        req_valid = 2'b11;
        @(negedge clk);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_grant", req_ready, 2'b01);
        if (req_ready[0]) begin
            acc_cyc = cyc;
            exp_q.push_back({1'b0, 32'h0002_0000});
            @(posedge clk);
            #1 req_valid = 2'b00;
            @(negedge clk);
            wait_rsp(0);
        end
        req_valid = 2'b00;

        chk("queue_empty", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
